pulse_meas: RTL

PULSE_MEAS -- requirements
Module: pulse_meas

---
 rtl/pulse_meas.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pulse_meas.sv
// Pulse-width meter: synchronizes pulse_in, times its high phase in clk cycles
// and hands each accepted width to a consumer through a valid/ack hold register.
module pulse_meas #(
   parameter int CNT_W     = 32,
   parameter int MIN_WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             pulse_in,
   input  logic             width_ack,
   output logic [CNT_W-1:0] width_out,
   output logic             width_valid,
   output logic             ovf_out,
   output logic             overrun_out,
   output logic [15:0]      runt_cnt,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, WAIT_LOW, ARMED, MEASURE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WIDTH);

   state_t             state_q, state_d;
   logic               sync1_q, sync1_d;
   logic               s_in_q, s_in_d;
   logic               s_prev_q, s_prev_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [CNT_W-1:0]   width_q, width_d;
   logic               valid_q, valid_d;
   logic               ovf_out_q, ovf_out_d;
   logic               overrun_q, overrun_d;
   logic [15:0]        runt_q, runt_d;
   logic               done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:     state_d = s_in_q ? WAIT_LOW : ARMED;
            WAIT_LOW: if (!s_in_q) state_d = ARMED;
            ARMED:    if (s_in_q && !s_prev_q) state_d = MEASURE;
            MEASURE:  if (!s_in_q) state_d = ARMED;
            default:  state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state_q == WAIT_LOW) || (state_q == MEASURE);
   end

   // Counting plus result hand-off; a falling edge seen in MEASURE closes the pulse.
   always_comb begin
      sync1_d   = pulse_in;
      s_in_d    = sync1_q;
      s_prev_d  = s_in_q;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      width_d   = width_q;
      valid_d   = valid_q;
      ovf_out_d = ovf_out_q;
      overrun_d = overrun_q;
      runt_d    = runt_q;
      done      = en && (state_q == MEASURE) && !s_in_q;

      if (width_ack) valid_d = 1'b0;

      if (en) begin
         unique case (state_q)
            ARMED: begin
               if (s_in_q && !s_prev_q) cnt_d = CNT_W'(1);
            end
            MEASURE: begin
               if (s_in_q) begin
                  if (cnt_q == CNT_MAX) begin
                     cnt_d = cnt_q;
                     ovf_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                     ovf_d = ovf_q;
                  end
               end
            end
            default: begin
               cnt_d = '0;
            end
         endcase
      end

      if (done) begin
         if (cnt_q < MIN_CNT) begin
            if (runt_q != 16'hFFFF) runt_d = runt_q + 16'd1;
         end else if (!valid_q || width_ack) begin
            width_d   = cnt_q;
            ovf_out_d = ovf_q;
            valid_d   = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         s_in_q    <= 1'b0;
         s_prev_q  <= 1'b0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         width_q   <= '0;
         valid_q   <= 1'b0;
         ovf_out_q <= 1'b0;
         overrun_q <= 1'b0;
         runt_q    <= '0;
      end else begin
         sync1_q   <= sync1_d;
         s_in_q    <= s_in_d;
         s_prev_q  <= s_prev_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         width_q   <= width_d;
         valid_q   <= valid_d;
         ovf_out_q <= ovf_out_d;
         overrun_q <= overrun_d;
         runt_q    <= runt_d;
      end
   end

   assign width_out   = width_q;
   assign width_valid = valid_q;
   assign ovf_out     = ovf_out_q;
   assign overrun_out = overrun_q;
   assign runt_cnt    = runt_q;

endmodule
